// File: rtl/decode_pkg.sv
// Shared encodings for the ID-stage decoder and the EX-stage forwarding unit:
// opcode/funct values, ALU operation codes and forward-select codes.
package decode_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_LUI   = 4'd8,
    ALU_PASSA = 4'd9
  } alu_op_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic    reg_dst;
    logic    mem_read;
    logic    mem_to_reg;
    logic    mem_write;
    logic    alu_src;
    logic    reg_write;
    alu_op_e alu_op;
    logic    ext_op;
    logic    shift_index;
    logic    shift_dir;
    logic    alu_a_src;
    logic    call;
    logic    is_beq;
    logic    is_bne;
    logic    jump;
    logic    full_jump;
  } ctrl_t;

endpackage

// File: rtl/fwd_select.sv
// Forward-select for one EX-stage source operand; MEM result beats WB data,
// and register $0 is never forwarded.
module fwd_select
  import decode_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          mem_we_i,
  input  logic [RW-1:0] mem_rd_i,
  input  logic          wb_we_i,
  input  logic [RW-1:0] wb_rd_i,
  input  logic [RW-1:0] src_i,
  output logic [1:0]    sel_o
);

  // Priority compare: MEM first, then WB, else register file
  always_comb begin
    sel_o = FWD_RF;
    if (mem_we_i && (mem_rd_i != '0) && (mem_rd_i == src_i))
      sel_o = FWD_MEM;
    else if (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == src_i))
      sel_o = FWD_WB;
  end

endmodule

// File: rtl/decode_forward_ctrl.sv
// Main decoder, immediate extender and EX forwarding unit for the 5-stage
// MIPS pipeline, plus a sticky illegal-instruction flag.
// Build option: define FORWARD_EN to enable forwarding; otherwise
// ForwardA/ForwardB are tied to the register-file select.
module decode_forward_ctrl
  import decode_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    Opcode,
  input  logic [5:0]    Funct,
  input  logic [15:0]   Imm16,
  output logic          RegDst,
  output logic          MemRead,
  output logic          MemtoReg,
  output logic          MemWrite,
  output logic          ALUSrc,
  output logic          RegWrite,
  output logic [3:0]    ALUOp,
  output logic          EXTOP,
  output logic          ShiftIndex,
  output logic          ShiftDirection,
  output logic          ALUasrc,
  output logic          call,
  output logic          IsBeq,
  output logic          IsBne,
  output logic          Jump,
  output logic          FullJump,
  output logic [DW-1:0] Imm32,
  input  logic          mem_RegWrite,
  input  logic          wb_RegWrite,
  input  logic [RW-1:0] mem_RegisterRd,
  input  logic [RW-1:0] wb_RegisterRd,
  input  logic [RW-1:0] exe_RegisterRs,
  input  logic [RW-1:0] exe_RegisterRt,
  output logic [1:0]    ForwardA,
  output logic [1:0]    ForwardB,
  output logic          illegal
);

  ctrl_t ctl;
  logic  valid;
  logic  illegal_q, illegal_d;

  // Main decode: everything defaults to a bubble, legal encodings raise their controls
  always_comb begin
    ctl   = '0;
    ctl.alu_op = ALU_ADD;
    valid = 1'b1;
    unique case (Opcode)
      OP_RTYPE: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
        unique case (Funct)
          FN_ADD, FN_ADDU: ctl.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: ctl.alu_op = ALU_SUB;
          FN_AND:          ctl.alu_op = ALU_AND;
          FN_OR:           ctl.alu_op = ALU_OR;
          FN_XOR:          ctl.alu_op = ALU_XOR;
          FN_NOR:          ctl.alu_op = ALU_NOR;
          FN_SLT:          ctl.alu_op = ALU_SLT;
          FN_SLTU:         ctl.alu_op = ALU_SLTU;
          FN_SLL, FN_SRL, FN_SLLV, FN_SRLV: begin
            ctl.alu_a_src   = 1'b1;
            ctl.alu_op      = ALU_PASSA;
            ctl.shift_dir   = Funct[1];
            ctl.shift_index = Funct[2];
          end
          FN_JR: begin
            ctl.reg_write = 1'b0;
            ctl.jump      = 1'b1;
            ctl.full_jump = 1'b1;
          end
          FN_JALR: begin
            ctl.jump      = 1'b1;
            ctl.full_jump = 1'b1;
            ctl.call      = 1'b1;
          end
          default: begin
            ctl   = '0;
            valid = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
        ctl.alu_src   = 1'b1;
        ctl.reg_write = 1'b1;
        unique case (Opcode)
          OP_SLTI:  begin ctl.alu_op = ALU_SLT;  ctl.ext_op = 1'b1; end
          OP_SLTIU: begin ctl.alu_op = ALU_SLTU; ctl.ext_op = 1'b1; end
          OP_ANDI:  ctl.alu_op = ALU_AND;
          OP_ORI:   ctl.alu_op = ALU_OR;
          OP_XORI:  ctl.alu_op = ALU_XOR;
          OP_LUI:   ctl.alu_op = ALU_LUI;
          OP_LW: begin
            ctl.ext_op     = 1'b1;
            ctl.mem_read   = 1'b1;
            ctl.mem_to_reg = 1'b1;
          end
          default:  ctl.ext_op = 1'b1;  // addi / addiu
        endcase
      end
      OP_SW: begin
        ctl.ext_op    = 1'b1;
        ctl.alu_src   = 1'b1;
        ctl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctl.is_beq = 1'b1;
        ctl.ext_op = 1'b1;
      end
      OP_BNE: begin
        ctl.is_bne = 1'b1;
        ctl.ext_op = 1'b1;
      end
      OP_J:   ctl.jump = 1'b1;
      OP_JAL: begin
        ctl.jump      = 1'b1;
        ctl.call      = 1'b1;
        ctl.reg_write = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

  assign RegDst         = ctl.reg_dst;
  assign MemRead        = ctl.mem_read;
  assign MemtoReg       = ctl.mem_to_reg;
  assign MemWrite       = ctl.mem_write;
  assign ALUSrc         = ctl.alu_src;
  assign RegWrite       = ctl.reg_write;
  assign ALUOp          = ctl.alu_op;
  assign EXTOP          = ctl.ext_op;
  assign ShiftIndex     = ctl.shift_index;
  assign ShiftDirection = ctl.shift_dir;
  assign ALUasrc        = ctl.alu_a_src;
  assign call           = ctl.call;
  assign IsBeq          = ctl.is_beq;
  assign IsBne          = ctl.is_bne;
  assign Jump           = ctl.jump;
  assign FullJump       = ctl.full_jump;

  assign Imm32 = {{(DW-16){ctl.ext_op & Imm16[15]}}, Imm16};

`ifdef FORWARD_EN
  fwd_select #(.RW(RW)) u_fwd_a (
    .mem_we_i (mem_RegWrite),
    .mem_rd_i (mem_RegisterRd),
    .wb_we_i  (wb_RegWrite),
    .wb_rd_i  (wb_RegisterRd),
    .src_i    (exe_RegisterRs),
    .sel_o    (ForwardA)
  );

  fwd_select #(.RW(RW)) u_fwd_b (
    .mem_we_i (mem_RegWrite),
    .mem_rd_i (mem_RegisterRd),
    .wb_we_i  (wb_RegWrite),
    .wb_rd_i  (wb_RegisterRd),
    .src_i    (exe_RegisterRt),
    .sel_o    (ForwardB)
  );
`else
  // Hazards resolved by stalls elsewhere; tag inputs are intentionally sunk
  logic unused_fwd;
  assign unused_fwd = ^{mem_RegWrite, wb_RegWrite, mem_RegisterRd,
                        wb_RegisterRd, exe_RegisterRs, exe_RegisterRt};
  assign ForwardA = FWD_RF;
  assign ForwardB = FWD_RF;
`endif

  // Sticky flag: reset wins, otherwise an undefined decode latches it high
  always_comb begin
    illegal_d = illegal_q | ~valid;
  end

  // Illegal flag register
  always_ff @(posedge clk) begin
    if (!rst) illegal_q <= 1'b0;
    else      illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_decode_forward_ctrl.sv
// Directed self-checking bench for decode_forward_ctrl. Expected forwarding
// selects follow the FORWARD_EN build option.
module tb_decode_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  Opcode, Funct;
  logic [15:0] Imm16;
  logic        RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic [3:0]  ALUOp;
  logic        EXTOP, ShiftIndex, ShiftDirection, ALUasrc, call;
  logic        IsBeq, IsBne, Jump, FullJump;
  logic [31:0] Imm32;
  logic        mem_RegWrite, wb_RegWrite;
  logic [4:0]  mem_RegisterRd, wb_RegisterRd, exe_RegisterRs, exe_RegisterRt;
  logic [1:0]  ForwardA, ForwardB;
  logic        illegal;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [14:0] ctl;
  assign ctl = {RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, EXTOP,
                ShiftIndex, ShiftDirection, ALUasrc, call, IsBeq, IsBne,
                Jump, FullJump};

  always #5 clk = ~clk;

  decode_forward_ctrl #(.DW(32), .RW(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .Opcode         (Opcode),
    .Funct          (Funct),
    .Imm16          (Imm16),
    .RegDst         (RegDst),
    .MemRead        (MemRead),
    .MemtoReg       (MemtoReg),
    .MemWrite       (MemWrite),
    .ALUSrc         (ALUSrc),
    .RegWrite       (RegWrite),
    .ALUOp          (ALUOp),
    .EXTOP          (EXTOP),
    .ShiftIndex     (ShiftIndex),
    .ShiftDirection (ShiftDirection),
    .ALUasrc        (ALUasrc),
    .call           (call),
    .IsBeq          (IsBeq),
    .IsBne          (IsBne),
    .Jump           (Jump),
    .FullJump       (FullJump),
    .Imm32          (Imm32),
    .mem_RegWrite   (mem_RegWrite),
    .wb_RegWrite    (wb_RegWrite),
    .mem_RegisterRd (mem_RegisterRd),
    .wb_RegisterRd  (wb_RegisterRd),
    .exe_RegisterRs (exe_RegisterRs),
    .exe_RegisterRt (exe_RegisterRt),
    .ForwardA       (ForwardA),
    .ForwardB       (ForwardB),
    .illegal        (illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] imm);
    Opcode = op;
    Funct  = fn;
    Imm16  = imm;
    #1;
  endtask

  task automatic fwd(input logic mw, input logic [4:0] mrd, input logic ww,
                     input logic [4:0] wrd, input logic [4:0] rs, input logic [4:0] rt);
    mem_RegWrite   = mw;
    mem_RegisterRd = mrd;
    wb_RegWrite    = ww;
    wb_RegisterRd  = wrd;
    exe_RegisterRs = rs;
    exe_RegisterRt = rt;
    #1;
  endtask

  function automatic logic [1:0] fsel(input logic [1:0] enabled_val);
`ifdef FORWARD_EN
    return enabled_val;
`else
    return (enabled_val === 2'bxx) ? 2'b00 : 2'b00;
`endif
  endfunction

  initial begin
    rst = 1'b0;
    instr(6'h00, 6'h20, 16'h0000);
    fwd(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b1;

    // add $3,$1,$2
    instr(6'h00, 6'h20, 16'h1820);
    check("add_ctl",   {17'd0, ctl},   {17'd0, 15'b100001000000000});
    check("add_aluop", {28'd0, ALUOp}, 32'd0);

    // lw with negative offset: sign-extended
    instr(6'h23, 6'h3C, 16'hFFFC);
    check("lw_ctl",   {17'd0, ctl},   {17'd0, 15'b011011100000000});
    check("lw_aluop", {28'd0, ALUOp}, 32'd0);
    check("lw_imm",   Imm32,          32'hFFFFFFFC);

    // ori: zero-extended
    instr(6'h0D, 6'h3C, 16'hFFFC);
    check("ori_ctl",   {17'd0, ctl},   {17'd0, 15'b000011000000000});
    check("ori_aluop", {28'd0, ALUOp}, 32'd3);
    check("ori_imm",   Imm32,          32'h0000FFFC);

    // slti sign-extends
    instr(6'h0A, 6'h00, 16'h8000);
    check("slti_aluop", {28'd0, ALUOp}, 32'd6);
    check("slti_imm",   Imm32,          32'hFFFF8000);

    // lui
    instr(6'h0F, 6'h00, 16'h8001);
    check("lui_aluop", {28'd0, ALUOp}, 32'd8);
    check("lui_imm",   Imm32,          32'h00008001);

    // sltu R-type
    instr(6'h00, 6'h2B, 16'h0000);
    check("sltu_aluop", {28'd0, ALUOp}, 32'd7);

    // srlv
    instr(6'h00, 6'h06, 16'h0000);
    check("srlv_ctl",   {17'd0, ctl},   {17'd0, 15'b100001011100000});
    check("srlv_aluop", {28'd0, ALUOp}, 32'd9);

    // jalr
    instr(6'h00, 6'h09, 16'h0000);
    check("jalr_ctl", {17'd0, ctl}, {17'd0, 15'b100001000010011});

    // sw, beq, jal
    instr(6'h2B, 6'h00, 16'h0010);
    check("sw_ctl",  {17'd0, ctl}, {17'd0, 15'b000110100000000});
    instr(6'h04, 6'h00, 16'hFFFF);
    check("beq_ctl", {17'd0, ctl}, {17'd0, 15'b000000100001000});
    check("beq_imm", Imm32,        32'hFFFFFFFF);
    instr(6'h03, 6'h00, 16'h0000);
    check("jal_ctl", {17'd0, ctl}, {17'd0, 15'b000001000010010});

    // all-zero instruction is sll $0,$0,0 and legal
    instr(6'h00, 6'h00, 16'h0000);
    check("nop_ctl",   {17'd0, ctl},   {17'd0, 15'b100001000100000});
    check("nop_aluop", {28'd0, ALUOp}, 32'd9);
    @(posedge clk); #1;
    check("legal_no_flag", {31'd0, illegal}, 32'd0);

    // forwarding
    fwd(1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd7);
    check("fwdA_mem_prio", {30'd0, ForwardA}, {30'd0, fsel(2'b10)});
    check("fwdB_nomatch",  {30'd0, ForwardB}, {30'd0, fsel(2'b00)});
    fwd(1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 5'd7);
    check("fwdA_wb", {30'd0, ForwardA}, {30'd0, fsel(2'b01)});
    fwd(1'b1, 5'd9, 1'b1, 5'd7, 5'd3, 5'd7);
    check("fwdB_wb",    {30'd0, ForwardB}, {30'd0, fsel(2'b01)});
    check("fwdA_none",  {30'd0, ForwardA}, {30'd0, fsel(2'b00)});
    fwd(1'b1, 5'd7, 1'b0, 5'd7, 5'd3, 5'd7);
    check("fwdB_mem", {30'd0, ForwardB}, {30'd0, fsel(2'b10)});
    fwd(1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    check("fwdA_r0", {30'd0, ForwardA}, {30'd0, fsel(2'b00)});
    check("fwdB_r0", {30'd0, ForwardB}, {30'd0, fsel(2'b00)});

    // undefined funct: bubble and flag
    instr(6'h00, 6'h01, 16'h1234);
    check("badfn_ctl", {17'd0, ctl}, 32'd0);
    @(posedge clk); #1;
    check("badfn_flag", {31'd0, illegal}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("reset_clears", {31'd0, illegal}, 32'd0);

    // undefined opcode: bubble, flag sets and holds
    instr(6'h3F, 6'h20, 16'h8000);
    check("op3f_ctl",   {17'd0, ctl},   32'd0);
    check("op3f_aluop", {28'd0, ALUOp}, 32'd0);
    check("op3f_imm",   Imm32,          32'h00008000);
    check("op3f_before_edge", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1;
    check("op3f_flag", {31'd0, illegal}, 32'd1);
    instr(6'h00, 6'h20, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("flag_held", {31'd0, illegal}, 32'd1);

    // reset wins over a simultaneous illegal decode
    instr(6'h3F, 6'h00, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_wins", {31'd0, illegal}, 32'd0);
    rst = 1'b1;
    instr(6'h08, 6'h00, 16'h0001);
    @(posedge clk); #1;
    check("legal_after_reset", {31'd0, illegal}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_forward_ctrl.md
Name: decode_forward_ctrl

Overview:
- Combinational main decoder, 16→32 immediate extender and EX-stage forwarding unit for the 5-stage MIPS pipeline.
- Decode and extend operate on the ID-stage instruction; forwarding operates on EX/MEM/WB register tags.
- One clocked element: a sticky illegal-instruction flag.

Parameters:
- DW, 32, datapath/immediate output width.
- RW, 5, register index width.

Ports:
- clk  in  1  clock; flag updates on rising edge.
- rst  in  1  synchronous reset, active-low (rst=0 at a rising edge clears state).
- Opcode  in  6  id_inst[31:26].
- Funct  in  6  id_inst[5:0].
- Imm16  in  16  id_inst[15:0].
- RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  out  1 each  standard MIPS controls; RegDst=1 selects rd.
- ALUOp  out  4  ALU operation code.
- EXTOP  out  1  1=sign-extend, 0=zero-extend.
- ShiftIndex  out  1  1=shift amount from rs[4:0], 0=shamt.
- ShiftDirection  out  1  1=right (logical), 0=left.
- ALUasrc  out  1  1=ALU A input takes shifter output.
- call  out  1  write PC+4 to $31 (jal/jalr).
- IsBeq, IsBne  out  1 each  branch type.
- Jump  out  1  unconditional jump taken.
- FullJump  out  1  jump target from rs (jr/jalr).
- Imm32  out  DW  extended immediate.
- mem_RegWrite, wb_RegWrite  in  1 each  write enables of the MEM and WB instructions.
- mem_RegisterRd, wb_RegisterRd, exe_RegisterRs, exe_RegisterRt  in  RW each  register tags.
- ForwardA, ForwardB  out  2 each  00=register file, 01=WB write data, 10=MEM ALU result; 11 is never driven.
- illegal  out  1  sticky flag: an undefined opcode/funct was decoded.

Behaviour:
- ALUOp codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 LUI (B<<16), 9 PASSA.
- Every control output defaults to 0; each instruction asserts only the outputs listed for it.
- R-type (Opcode 0): RegDst=1, RegWrite=1.
  - funct 20/21 ADD; 22/23 SUB; 24 AND; 25 OR; 26 XOR; 27 NOR; 2A SLT; 2B SLTU.
  - sll 00: ALUasrc=1, ALUOp=PASSA, ShiftDirection=0, ShiftIndex=0.
  - srl 02: as sll but ShiftDirection=1.
  - sllv 04 / srlv 06: as sll/srl with ShiftIndex=1.
  - jr 08: RegWrite=0, Jump=1, FullJump=1.
  - jalr 09: Jump=1, FullJump=1, call=1, RegWrite=1.
- I-type, all ALUSrc=1, RegWrite=1:
  - addi 08 / addiu 09: ADD, EXTOP=1.
  - slti 0A: SLT, EXTOP=1. sltiu 0B: SLTU, EXTOP=1.
  - andi 0C: AND, EXTOP=0. ori 0D: OR, EXTOP=0. xori 0E: XOR, EXTOP=0.
  - lui 0F: LUI, EXTOP=0.
  - lw 23: ADD, EXTOP=1, MemRead=1, MemtoReg=1.
- Store, branch and jump opcodes:
  - sw 2B: ADD, EXTOP=1, ALUSrc=1, MemWrite=1, RegWrite=0.
  - beq 04: IsBeq=1, EXTOP=1. bne 05: IsBne=1, EXTOP=1.
  - j 02: Jump=1. jal 03: Jump=1, call=1, RegWrite=1.
- Undefined opcode or funct: all controls 0 (bubble), so no architectural side effect.
- Imm32 = EXTOP ? {16{Imm16[15]},Imm16} : {16'b0,Imm16}.
- Forwarding, evaluated separately for A (Rs) and B (Rt):
  - 10 if mem_RegWrite and mem_RegisterRd≠0 and mem_RegisterRd==src.
  - Otherwise 01 if wb_RegWrite and wb_RegisterRd≠0 and wb_RegisterRd==src.
  - Otherwise 00.
  - MEM has priority over WB when both match.
- Decode, extend and forwarding are purely combinational: zero-cycle latency, no X on any output for defined inputs.
- illegal register:
  - rst=0 at a clock edge → illegal=0; reset wins over a simultaneous illegal decode.
  - Otherwise it sets to 1 on an edge where the decode is undefined and holds until reset.
  - The all-zero instruction (sll $0,$0,0) is legal.

Optional Feature:
- FORWARD_EN defined: forwarding logic as above.
- FORWARD_EN undefined: ForwardA=ForwardB=00 constantly, the forwarding inputs are unused, and hazards are left to stalls elsewhere.

Decomposition:
- Shared package decode_pkg: opcode and funct localparams, ALUOp codes, forward-select codes (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
- One sub-module, fwd_select, instantiated twice (A and B); decoder and extender stay inline.

Test Plan:
- add $3,$1,$2 (Op 00, Funct 20) → RegDst=1, RegWrite=1, ALUOp=0, ALUSrc=0, all others 0.
- lw (Op 23, Imm16=FFFC) → Imm32=FFFFFFFC, MemRead=1, MemtoReg=1, ALUSrc=1. ori (Op 0D, Imm16=FFFC) → Imm32=0000FFFC.
- srlv (Funct 06) → ALUasrc=1, ShiftIndex=1, ShiftDirection=1, ALUOp=9. jalr (Funct 09) → Jump=1, FullJump=1, call=1.
- Forwarding, exe_RegisterRs=5, mem_RegisterRd=5, wb_RegisterRd=5, both RegWrite=1 → ForwardA=10. With mem_RegWrite=0 → ForwardA=01.
- Forwarding, all tags = 0, both RegWrite=1 → ForwardA=ForwardB=00.
- Opcode 3F → all controls 0; illegal=1 after the edge and held. Reset with rst=0 at an edge → illegal=0.
